cpu: RTL and testbench



---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/register_file.sv | 37 +++
 rtl/cpu.sv | 179 +++++++++++++++++
 tb/tb_cpu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle core: opcode and FSM state
// encodings, instruction field positions and the imm6 sign-extension helper.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SLT   = 4'h5,
        OP_ADDI  = 4'h6,
        OP_LW    = 4'h7,
        OP_SW    = 4'h8,
        OP_BEQ   = 4'h9,
        OP_LUI   = 4'hA,
        OP_JAL   = 4'hB,
        OP_JR    = 4'hC,
        OP_NOP_D = 4'hD,
        OP_NOP_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    // Instruction field positions.
    localparam int unsigned F_OP_HI   = 15;
    localparam int unsigned F_OP_LO   = 12;
    localparam int unsigned F_RD_HI   = 11;
    localparam int unsigned F_RD_LO   = 9;
    localparam int unsigned F_RS1_HI  = 8;
    localparam int unsigned F_RS1_LO  = 6;
    localparam int unsigned F_RS2_HI  = 5;
    localparam int unsigned F_RS2_LO  = 3;
    localparam int unsigned F_IMM6_HI = 5;
    localparam int unsigned F_IMM9_HI = 8;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/register_file.sv
// Register file for the core.
// Ports:
//   clk, rst          clock and synchronous active-high reset (clears all)
//   raddr_a/rdata_a   combinational read port A
//   raddr_b/rdata_b   combinational read port B
//   we/waddr/wdata    synchronous write port; writes to r0 are ignored
module register_file #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] registers [0:NREGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            registers <= '{default: '0};
        end else if (we && (waddr != '0)) begin
            registers[waddr] <= wdata;
        end
    end

    // r0 is hard-wired to zero on reads as well as write-protected.
    assign rdata_a = (raddr_a == '0) ? '0 : registers[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : registers[raddr_b];

endmodule

// File: rtl/cpu.sv
// 16-bit multicycle RISC core. Every instruction takes two clocks: FETCH
// latches the word at pc into ir, EXECUTE decodes it, performs the ALU or
// memory operation and commits register/pc updates on its closing edge.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mem_rdata  word read at mem_addr[7:1] (combinational, same cycle)
//   mem_addr   byte address to memory (bit 0 ignored by memory)
//   mem_wdata  store data
//   mem_we     store strobe, memory writes on the posedge where it is high
//   halted     high once HALT has executed
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              halted
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [DATA_W-1:0] ir, ir_next;
    logic              halted_next;

    opcode_t           op;
    logic [2:0]        rd, rs1, rs2, rb_addr;
    logic [DATA_W-1:0] imm6_sx;
    logic [DATA_W-1:0] rs1_val, rb_val;
    logic [ADDR_W-1:0] pc_plus2, ea, br_off, jal_off;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              store;

    // Decode
    assign op       = opcode_t'(ir[F_OP_HI:F_OP_LO]);
    assign rd       = ir[F_RD_HI:F_RD_LO];
    assign rs1      = ir[F_RS1_HI:F_RS1_LO];
    assign rs2      = ir[F_RS2_HI:F_RS2_LO];
    assign imm6_sx  = sext6(ir[F_IMM6_HI:0]);

    // SW stores rd and BEQ compares rd, so port B reads rd for those two.
    assign rb_addr  = ((op == OP_SW) || (op == OP_BEQ)) ? rd : rs2;

    assign pc_plus2 = pc + ADDR_W'(2);
    assign ea       = rs1_val[ADDR_W-1:0] + imm6_sx[ADDR_W-1:0];
    assign br_off   = {imm6_sx[ADDR_W-2:0], 1'b0};
    // Only the low bits of sext(imm9)<<1 survive the pc width.
    assign jal_off  = {ir[ADDR_W-2:0], 1'b0};

    register_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) register_file (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs1),
        .rdata_a (rs1_val),
        .raddr_b (rb_addr),
        .rdata_b (rb_val),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= '0;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            ir     <= ir_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ir_next     = ir;
        halted_next = halted;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        mem_addr    = pc;
        store       = 1'b0;

        case (state)
            S_FETCH: begin
                ir_next    = mem_rdata;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc_plus2;
                case (op)
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val + rb_val;
                    end
                    OP_SUB: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val - rb_val;
                    end
                    OP_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val & rb_val;
                    end
                    OP_OR: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val | rb_val;
                    end
                    OP_XOR: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val ^ rb_val;
                    end
                    OP_SLT: begin
                        rf_we    = 1'b1;
                        rf_wdata = {{(DATA_W-1){1'b0}},
                                    ($signed(rs1_val) < $signed(rb_val))};
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val + imm6_sx;
                    end
                    OP_LW: begin
                        mem_addr = ea;
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    OP_SW: begin
                        mem_addr = ea;
                        store    = 1'b1;
                    end
                    OP_BEQ: begin
                        if (rb_val == rs1_val) begin
                            pc_next = pc + br_off;
                        end
                    end
                    OP_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = {ir[F_IMM9_HI:0], 7'b0};
                    end
                    OP_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc_plus2};
                        pc_next  = pc + jal_off;
                    end
                    OP_JR: begin
                        pc_next = {rs1_val[ADDR_W-1:1], 1'b0};
                    end
                    OP_HALT: begin
                        // Stay in EXECUTE on HALT so it re-executes forever.
                        pc_next     = pc;
                        state_next  = S_EXEC;
                        halted_next = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign mem_wdata = rb_val;
    // Reset must also cancel a store whose EXECUTE edge coincides with it.
    assign mem_we    = store & ~rst;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        halted;

    int n_checks;
    int n_errors;

    cpu #(
        .DATA_W (16),
        .ADDR_W (8),
        .NREGS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 128 x 16 memory with a side loading port for the bench.
    logic [15:0] mem [0:127];
    logic        clr_en;
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [15:0] ld_data;
    int unsigned we_count;

    always @(posedge clk) begin
        if (clr_en) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            we_count <= 0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr[7:1]] <= mem_wdata;
            we_count <= we_count + 1;
        end
    end

    assign mem_rdata = mem[mem_addr[7:1]];

    typedef struct {
        logic [7:0]  pc;
        int unsigned rix;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] reg_val(input int unsigned i);
        logic [2:0] idx;
        idx = i[2:0];
        return dut.register_file.registers[idx];
    endfunction

    task automatic load_word(input logic [6:0] widx, input logic [15:0] w);
        ld_addr = widx;
        ld_data = w;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
    endtask

    // Load one instruction and queue what must hold right after it commits.
    task automatic prog(input logic [7:0] addr, input logic [15:0] w,
                        input logic [7:0] pc_after, input int unsigned rix,
                        input logic [15:0] val);
        exp_t e;
        load_word(addr[7:1], w);
        e.pc  = pc_after;
        e.rix = rix;
        e.val = val;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        int   n;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        clr_en   = 1'b1;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        @(posedge clk);
        #1;
        clr_en = 1'b0;

        // Program in execution order; skipped words loaded separately.
        prog(8'h00, 16'h620A, 8'h02, 1, 16'h000A); // ADDI r1,r0,10
        prog(8'h02, 16'h6402, 8'h04, 2, 16'h0002); // ADDI r2,r0,2
        prog(8'h04, 16'h0650, 8'h06, 3, 16'h000C); // ADD r3,r1,r2
        prog(8'h06, 16'hA9FF, 8'h08, 4, 16'hFF80); // LUI r4,0x1FF
        prog(8'h08, 16'h693F, 8'h0A, 4, 16'hFF7F); // ADDI r4,r4,-1
        prog(8'h0A, 16'h886A, 8'h0C, 4, 16'hFF7F); // SW r4,[r1-22] -> 0xF4
        prog(8'h0C, 16'h7A6B, 8'h0E, 5, 16'hFF7F); // LW r5,[r1-21] -> 0xF5 odd
        prog(8'h0E, 16'h6005, 8'h10, 0, 16'h0000); // ADDI r0,r0,5
        prog(8'h10, 16'h6E01, 8'h12, 7, 16'h0001); // ADDI r7,r0,1
        prog(8'h12, 16'h1C38, 8'h14, 6, 16'hFFFF); // SUB r6,r0,r7
        prog(8'h14, 16'hA700, 8'h16, 3, 16'h8000); // LUI r3,0x100
        prog(8'h16, 16'h54F8, 8'h18, 2, 16'h0001); // SLT r2,r3,r7
        prog(8'h18, 16'h55D8, 8'h1A, 2, 16'h0000); // SLT r2,r7,r3
        prog(8'h1A, 16'h9002, 8'h1E, 1, 16'h000A); // BEQ r0,r0,+2 (taken)
        load_word(7'h0E, 16'h621F);                // skipped: ADDI r1,r0,31
        prog(8'h1E, 16'h93C5, 8'h20, 1, 16'h000A); // BEQ r1,r7,+5 (not taken)
        prog(8'h20, 16'hBDEF, 8'hFE, 6, 16'h0022); // JAL r6,-17
        prog(8'hFE, 16'hBC12, 8'h22, 6, 16'h0000); // JAL r6,+18, link wraps
        prog(8'h22, 16'hB002, 8'h26, 0, 16'h0000); // JAL r0,+2
        load_word(7'h12, 16'h621F);                // skipped
        prog(8'h26, 16'h645F, 8'h28, 2, 16'h0029); // ADDI r2,r1,31
        prog(8'h28, 16'h6486, 8'h2A, 2, 16'h002F); // ADDI r2,r2,6
        prog(8'h2A, 16'hC080, 8'h2E, 2, 16'h002F); // JR r2 -> 0x2E
        load_word(7'h16, 16'h621F);                // skipped
        prog(8'h2E, 16'h2708, 8'h30, 3, 16'h000A); // AND r3,r4,r1
        prog(8'h30, 16'h3738, 8'h32, 3, 16'hFF7F); // OR r3,r4,r7
        prog(8'h32, 16'h4708, 8'h34, 3, 16'hFF75); // XOR r3,r4,r1
        prog(8'h34, 16'hD000, 8'h36, 0, 16'h0000); // NOP
        prog(8'h36, 16'hE000, 8'h38, 5, 16'hFF7F); // NOP
        prog(8'h38, 16'h0B20, 8'h3A, 5, 16'hFEFE); // ADD r5,r4,r4 (wrap)
        prog(8'h3A, 16'h706B, 8'h3C, 0, 16'h0000); // LW r0,[r1-21]
        prog(8'h3C, 16'hF000, 8'h3C, 0, 16'h0000); // HALT

        // Reset state
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h00);
        check_eq("rst_mem_we", 32'(mem_we), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        for (int r = 0; r < 8; r++)
            check_eq($sformatf("rst_r%0d", r), 32'(reg_val(r)), 32'h0);

        rst = 1'b0;
        n = sbq.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            check_eq($sformatf("pc_i%0d", k), 32'(mem_addr), 32'(e.pc));
            check_eq($sformatf("r%0d_i%0d", e.rix, k), 32'(reg_val(e.rix)), 32'(e.val));
        end

        check_eq("halted", 32'(halted), 32'h1);
        check_eq("store_count", 32'(we_count), 32'd1);
        check_eq("store_data", 32'(mem[7'h7A]), 32'hFF7F);

        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("halt_pc_c%0d", c), 32'(mem_addr), 32'h3C);
            check_eq($sformatf("halt_we_c%0d", c), 32'(mem_we), 32'h0);
            check_eq($sformatf("halt_hold_c%0d", c), 32'(halted), 32'h1);
        end

        // Reset arriving in the EXECUTE cycle of a store.
        rst = 1'b1;
        load_word(7'h01, 16'h8210);                // SW r1,[r0+0x10]
        check_eq("rst2_halted", 32'(halted), 32'h0);
        check_eq("rst2_mem_addr", 32'(mem_addr), 32'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("rst2_r1", 32'(reg_val(1)), 32'h000A);
        check_eq("rst2_pc", 32'(mem_addr), 32'h02);
        @(posedge clk);
        #1;
        check_eq("sw_we", 32'(mem_we), 32'h1);
        check_eq("sw_addr", 32'(mem_addr), 32'h10);
        check_eq("sw_wdata", 32'(mem_wdata), 32'h000A);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_count", 32'(we_count), 32'd1);
        check_eq("abort_mem", 32'(mem[7'h08]), 32'h6E01);
        check_eq("abort_pc", 32'(mem_addr), 32'h00);
        check_eq("abort_halted", 32'(halted), 32'h0);
        for (int r = 0; r < 8; r++)
            check_eq($sformatf("abort_r%0d", r), 32'(reg_val(r)), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
